// File: rtl/snow64_mem_arbiter_pkg.sv
// Shared types and widths for the snow64 memory arbiter slice.
package snow64_mem_arbiter_pkg;

  // Widths of the CPU address and of one LAR data line.
  localparam int CPU_ADDR_W   = 64;
  localparam int LAR_DATA_W   = 256;
  // Channel index field in the tag is sized for the largest supported NUM_CH (8).
  localparam int MAX_CH_IDX_W = 3;

  typedef enum logic {
    MEM_ACC_READ  = 1'b0,
    MEM_ACC_WRITE = 1'b1
  } mem_acc_type_e;

  // One in-flight command: which channel owns the response and whether data returns.
  typedef struct packed {
    logic                    valid;
    logic [MAX_CH_IDX_W-1:0] ch;
    mem_acc_type_e           acc;
  } inflight_tag_t;

endpackage

// File: rtl/snow64_mem_arbiter_if.sv
// Requester and memory-port bundle for snow64_mem_arbiter.
//
// Handshake: req_valid[i] is a level held by channel i until it sees the
// one-cycle req_accepted[i] pulse; the channel has exactly one cycle after that
// pulse to drop or change its request before it becomes eligible again.
// rsp_valid[i] is a one-cycle pulse with no back-pressure. On the memory side
// mem_req is a one-cycle command and mem_valid acknowledges the oldest
// in-flight command; while it is low the arbiter freezes.
interface snow64_mem_arbiter_if
  import snow64_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = LAR_DATA_W
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_accepted;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_valid;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_valid, mem_rdata,
    output req_accepted, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, busy
  );

  // Requesters plus memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_valid, mem_rdata,
    input  req_accepted, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr,
           mem_wdata, busy
  );
endinterface

// File: rtl/snow64_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr.
module snow64_rr_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int CH_IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]   eligible,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic [NUM_CH-1:0]   grant_onehot,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                any_grant
);

  logic [CH_IDX_W-1:0] cand;

  // Channel index ptr+offs modulo NUM_CH; ptr is always below NUM_CH.
  function automatic logic [CH_IDX_W-1:0] rr_index(input logic [CH_IDX_W-1:0] base,
                                                   input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest eligible channel wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    cand         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = rr_index(ptr, k);
      if (eligible[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant_onehot = NUM_CH'(1) << grant_idx;
  end

endmodule

// File: rtl/snow64_mem_arbiter.sv
// Round-robin arbiter of NUM_CH requesters onto one fixed-latency memory port,
// with a MEM_LAT-deep tag pipeline routing each response back to its channel.
module snow64_mem_arbiter
  import snow64_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = LAR_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snow64_mem_arbiter_if.slave   bus
);

  localparam int CH_IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   accepted_q;
  logic [NUM_CH-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CH_IDX_W-1:0] rr_ptr_q;
  inflight_tag_t       tag_q [1:MEM_LAT];

  inflight_tag_t       tail;
  logic                stall;
  logic                tag_busy;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   grant_onehot;
  logic [CH_IDX_W-1:0] grant_idx;
  logic                any_grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign tail = tag_q[MEM_LAT];

  // Memory has not produced the oldest command's data: freeze issue and shift.
  assign stall = tail.valid && !bus.mem_valid;

  // A channel just accepted is skipped for one cycle so it can drop its request.
  assign eligible = bus.req_valid & ~accepted_q;

  snow64_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .CH_IDX_W (CH_IDX_W)
  ) u_rr (
    .eligible     (eligible),
    .ptr          (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  // Select the granted channel's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_onehot[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Any command still waiting somewhere in the tag pipeline.
  always_comb begin
    tag_busy = 1'b0;
    for (int k = 1; k <= MEM_LAT; k++) tag_busy = tag_busy | tag_q[k].valid;
  end

  // Stage 0: issue the granted command and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      accepted_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (stall) begin
      mem_req_q  <= 1'b0;
      accepted_q <= '0;
    end else begin
      mem_req_q  <= any_grant;
      accepted_q <= grant_onehot;
      if (any_grant) begin
        mem_we_q    <= sel_we;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        rr_ptr_q    <= (grant_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Tag pipeline: shifts one stage per unstalled edge, bubbles when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= MEM_LAT; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      tag_q[1] <= '{valid: any_grant,
                    ch:    MAX_CH_IDX_W'(grant_idx),
                    acc:   sel_we ? MEM_ACC_WRITE : MEM_ACC_READ};
      for (int k = 2; k <= MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Response: pulse the owning channel; only reads update the data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else if (!stall && tail.valid) begin
      rsp_valid_q <= NUM_CH'(1) << tail.ch;
      if (tail.acc == MEM_ACC_READ) rsp_rdata_q <= bus.mem_rdata;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign bus.req_accepted = accepted_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.busy         = mem_req_q | tag_busy;

endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// Bench for snow64_mem_arbiter: a 3-channel MEM_LAT=2 instance checked every
// cycle against a queue-based model, plus an 8-channel instance for pointer wrap.
module tb_snow64_mem_arbiter;
  import snow64_mem_arbiter_pkg::*;

  localparam int NCH   = 3;
  localparam int AW    = 64;
  localparam int DW    = 256;
  localparam int LAT   = 2;
  localparam int EXP_W = DW + 5;  // {we, ch[3:0], read data}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow64_mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus3 ();
  snow64_mem_arbiter_if #(.NUM_CH(8),   .ADDR_W(AW), .DATA_W(DW)) bus8 ();

  snow64_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  snow64_mem_arbiter #(.NUM_CH(8), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  // ---------------- reference model state ----------------
  logic [EXP_W-1:0] exp_q[$];   // expected responses in issue order
  int               age_q[$];   // unstalled edges still needed to reach the tail
  logic [DW-1:0]    mem_model [logic [AW-1:0]];
  int               rr_ptr;
  logic [NCH-1:0]   prev_acc;
  logic [DW-1:0]    last_rdata;
  logic [AW-1:0]    drv_addr  [NCH];
  logic [DW-1:0]    drv_wdata [NCH];
  int               rsp_cnt   [NCH];
  int               n_vec  = 0;
  int               n_miss = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{a ^ 64'hC0FF_EE00_5A5A_0000}};
  endfunction

  // ---------------- driver: one clock of the 3-channel instance ----------------
  task automatic step(input logic [NCH-1:0] rv, input logic [NCH-1:0] we, input logic mv);
    logic             stall;
    logic [NCH-1:0]   elig, exp_acc, exp_rsp;
    logic [DW-1:0]    exp_rd, exp_wd;
    logic [AW-1:0]    exp_addr;
    logic             exp_we, exp_busy;
    logic [EXP_W-1:0] head;
    int               g, c;

    @(negedge clk);
    bus3.req_valid = rv;
    bus3.req_we    = we;
    for (int i = 0; i < NCH; i++) begin
      bus3.req_addr[i*AW +: AW]  = drv_addr[i];
      bus3.req_wdata[i*DW +: DW] = drv_wdata[i];
    end
    bus3.mem_valid = mv;
    if (exp_q.size() > 0 && !exp_q[0][EXP_W-1]) bus3.mem_rdata = exp_q[0][DW-1:0];
    else                                         bus3.mem_rdata = rand_data();

    stall    = (exp_q.size() > 0) && (age_q[0] == 0) && !mv;
    exp_acc  = '0;
    exp_rsp  = '0;
    exp_rd   = last_rdata;
    exp_addr = '0;
    exp_we   = 1'b0;
    exp_wd   = '0;
    g        = -1;
    if (!stall) begin
      if (exp_q.size() > 0 && age_q[0] == 0) begin
        head = exp_q.pop_front();
        void'(age_q.pop_front());
        exp_rsp[head[DW+3:DW]] = 1'b1;
        if (!head[EXP_W-1]) exp_rd = head[DW-1:0];
      end
      foreach (age_q[j]) if (age_q[j] > 0) age_q[j]--;
      elig = rv & ~prev_acc;
      for (int k = 0; k < NCH; k++) begin
        c = (rr_ptr + k) % NCH;
        if (g < 0 && elig[c]) g = c;
      end
      if (g >= 0) begin
        exp_acc[g] = 1'b1;
        rr_ptr     = (g + 1) % NCH;
        exp_addr   = drv_addr[g];
        exp_we     = we[g];
        exp_wd     = drv_wdata[g];
        if (we[g]) begin
          mem_model[drv_addr[g]] = drv_wdata[g];
          exp_q.push_back({1'b1, 4'(g), {DW{1'b0}}});
        end else begin
          exp_q.push_back({1'b0, 4'(g), mem_rd(drv_addr[g])});
        end
        age_q.push_back(LAT - 1);
      end
    end
    prev_acc = exp_acc;
    exp_busy = exp_q.size() > 0;

    @(posedge clk);
    #1;
    check("req_accepted", DW'(bus3.req_accepted), DW'(exp_acc));
    check("mem_req", DW'(bus3.mem_req), DW'(g >= 0));
    if (g >= 0) begin
      check("mem_addr",  DW'(bus3.mem_addr), DW'(exp_addr));
      check("mem_we",    DW'(bus3.mem_we),   DW'(exp_we));
      check("mem_wdata", bus3.mem_wdata,     exp_wd);
    end
    check("rsp_valid", DW'(bus3.rsp_valid), DW'(exp_rsp));
    check("rsp_rdata", bus3.rsp_rdata, exp_rd);
    check("busy",      DW'(bus3.busy), DW'(exp_busy));
    for (int i = 0; i < NCH; i++) if (bus3.rsp_valid[i]) rsp_cnt[i]++;
    last_rdata = exp_rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"},   DW'(bus3.req_accepted), '0);
    check({tag, "_rspv"},  DW'(bus3.rsp_valid),    '0);
    check({tag, "_rspd"},  bus3.rsp_rdata,         '0);
    check({tag, "_mreq"},  DW'(bus3.mem_req),      '0);
    check({tag, "_mwe"},   DW'(bus3.mem_we),       '0);
    check({tag, "_maddr"}, DW'(bus3.mem_addr),     '0);
    check({tag, "_mwd"},   bus3.mem_wdata,         '0);
    check({tag, "_busy"},  DW'(bus3.busy),         '0);
  endtask

  // Asynchronous reset pulse between clock edges; model forgets in-flight work.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    age_q.delete();
    rr_ptr     = 0;
    prev_acc   = '0;
    last_rdata = '0;
    bus3.req_valid = '0;
    bus3.mem_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hard time limit in case the design wedges the simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    int base_cnt;
    logic [NCH-1:0] rv, we;

    bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.mem_valid = 1'b1; bus3.mem_rdata = '0;
    bus8.req_valid = '0; bus8.req_we = '0; bus8.req_addr = '0; bus8.req_wdata = '0;
    bus8.mem_valid = 1'b1; bus8.mem_rdata = '0;
    rr_ptr = 0; prev_acc = '0; last_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      drv_addr[i] = '0; drv_wdata[i] = '0; rsp_cnt[i] = 0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 8 channels: move pointer to 7 via ch6, then ch0 alone wraps and pointer goes to 1.
    @(negedge clk); bus8.req_valid = 8'h40;
    @(posedge clk); #1; check("rr8_ch6", DW'(bus8.req_accepted), DW'(8'h40));
    @(negedge clk); bus8.req_valid = 8'h01;
    @(posedge clk); #1; check("rr8_wrap_ch0", DW'(bus8.req_accepted), DW'(8'h01));
    @(negedge clk); bus8.req_valid = 8'h00;
    @(posedge clk); #1; check("rr8_idle", DW'(bus8.req_accepted), '0);
    @(negedge clk); bus8.req_valid = 8'h03;
    @(posedge clk); #1; check("rr8_ptr_is_1", DW'(bus8.req_accepted), DW'(8'h02));
    @(negedge clk); bus8.req_valid = 8'h00;

    // Single read on ch0: accept at edge 1, response at edge 3.
    mem_model[64'h40] = {32{8'hAB}};
    drv_addr[0] = 64'h40;
    step(3'b001, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);
    check("single_rd_valid", DW'(bus3.rsp_valid), DW'(3'b001));
    check("single_rd_data",  bus3.rsp_rdata, {32{8'hAB}});

    // Write then read on ch2, same address.
    base_cnt     = rsp_cnt[2];
    drv_addr[2]  = 64'h80;
    drv_wdata[2] = {32{8'h55}};
    step(3'b100, 3'b100, 1'b1);
    step(3'b000, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    repeat (3) step(3'b000, 3'b000, 1'b1);
    check("wr_rd_rsp_count", DW'(rsp_cnt[2] - base_cnt), DW'(2));
    check("wr_rd_data", bus3.rsp_rdata, {32{8'h55}});

    // Stall with two commands in flight: nothing issues while mem_valid is low.
    drv_addr[0] = 64'h100; drv_addr[1] = 64'h120; drv_addr[2] = 64'h140;
    step(3'b001, 3'b000, 1'b1);
    step(3'b010, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 3'b000, 1'b0);
      check("stall_no_mem_req", DW'(bus3.mem_req), '0);
    end
    repeat (4) step(3'b000, 3'b000, 1'b1);

    // Reset with ch1 in flight: no response after release.
    base_cnt = rsp_cnt[1];
    step(3'b010, 3'b000, 1'b1);
    mid_reset();
    repeat (4) step(3'b000, 3'b000, 1'b1);
    check("rst_no_rsp_ch1", DW'(rsp_cnt[1] - base_cnt), '0);

    // Round robin with all channels requesting from pointer 0.
    mid_reset();
    for (int k = 0; k < 9; k++) begin
      step(3'b111, 3'b000, 1'b1);
      check("rr_order", DW'(bus3.req_accepted), DW'(3'b001 << (k % 3)));
    end
    repeat (3) step(3'b000, 3'b000, 1'b1);

    // Randomised traffic with memory stalls and one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) mid_reset();
      for (int i = 0; i < NCH; i++) begin
        drv_addr[i]  = AW'($urandom_range(0, 7)) << 5;
        drv_wdata[i] = rand_data();
      end
      rv = NCH'($urandom_range(0, 7));
      we = NCH'($urandom_range(0, 7));
      step(rv, we, $urandom_range(0, 3) != 0);
    end
    repeat (6) step(3'b000, 3'b000, 1'b1);
    check("drained", DW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
